// File: rtl/riscv_multi_ctrl_pkg.sv
// Shared encodings for the multi-cycle RISC-V controller: states, datapath
// select codes, ALU operations and opcodes.
package riscv_multi_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_JALRADR  = 4'd10,
      S_JAL      = 4'd11,
      S_ERR      = 4'd12
   } state_t;

   // Which ALU decode table the current state needs
   typedef enum logic [1:0] {
      AC_ADD   = 2'd0,
      AC_SUB   = 2'd1,
      AC_RTYPE = 2'd2,
      AC_ITYPE = 2'd3
   } alu_class_t;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_SLL  = 4'd2;
   localparam logic [3:0] ALU_SLT  = 4'd3;
   localparam logic [3:0] ALU_SLTU = 4'd4;
   localparam logic [3:0] ALU_XOR  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_OR   = 4'd8;
   localparam logic [3:0] ALU_AND  = 4'd9;

   localparam logic [1:0] SRCA_PC    = 2'd0;
   localparam logic [1:0] SRCA_OLDPC = 2'd1;
   localparam logic [1:0] SRCA_RS1   = 2'd2;

   localparam logic [1:0] SRCB_RS2  = 2'd0;
   localparam logic [1:0] SRCB_IMM  = 2'd1;
   localparam logic [1:0] SRCB_FOUR = 2'd2;

   localparam logic [1:0] RES_ALUOUT  = 2'd0;
   localparam logic [1:0] RES_MEMDATA = 2'd1;
   localparam logic [1:0] RES_ALU     = 2'd2;

   localparam logic [1:0] IMM_I = 2'd0;
   localparam logic [1:0] IMM_S = 2'd1;
   localparam logic [1:0] IMM_B = 2'd2;
   localparam logic [1:0] IMM_J = 2'd3;

   localparam logic ADR_PC     = 1'b0;
   localparam logic ADR_ALUOUT = 1'b1;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

endpackage

// File: rtl/riscv_multi_ctrl_alu_dec.sv
// Combinational ALU operation decode from state class, funct3 and funct7[5].
import riscv_multi_ctrl_pkg::*;

module riscv_alu_dec (
   input  alu_class_t  alu_class,
   input  logic [2:0]  funct3,
   input  logic        funct7_5,
   output logic [3:0]  alu_ctrl
);

   always_comb begin
      alu_ctrl = ALU_ADD;
      case (alu_class)
         AC_ADD: alu_ctrl = ALU_ADD;
         AC_SUB: alu_ctrl = ALU_SUB;
         default: begin
            case (funct3)
               // I-type funct3=000 ignores bit 30, which belongs to the immediate
               3'b000:  alu_ctrl = (alu_class == AC_RTYPE && funct7_5) ? ALU_SUB : ALU_ADD;
               3'b001:  alu_ctrl = ALU_SLL;
               3'b010:  alu_ctrl = ALU_SLT;
               3'b011:  alu_ctrl = ALU_SLTU;
               3'b100:  alu_ctrl = ALU_XOR;
               3'b101:  alu_ctrl = funct7_5 ? ALU_SRA : ALU_SRL;
               3'b110:  alu_ctrl = ALU_OR;
               default: alu_ctrl = ALU_AND;
            endcase
         end
      endcase
   end

endmodule

// File: rtl/riscv_multi_ctrl.sv
// Multi-cycle RISC-V control FSM: sequences fetch/decode/execute/memory/
// writeback and drives all datapath selects and write enables.
import riscv_multi_ctrl_pkg::*;

module riscv_multi_ctrl #(
   parameter int unsigned RESET_PC_UPDATE = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instr,
   input  logic        zero,
   output logic        pc_we,
   output logic        ir_we,
   output logic        adr_src,
   output logic        mem_we,
   output logic        reg_we,
   output logic [1:0]  alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [3:0]  alu_ctrl,
   output logic [1:0]  imm_src,
   output logic [1:0]  res_src,
   output logic        err
);

   localparam logic PC_WE_IN_RESET = (RESET_PC_UPDATE != 0);

   state_t     state, state_next;
   alu_class_t alu_class;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       funct7_5;
   logic       unused_instr;

   assign opcode       = instr[6:0];
   assign funct3       = instr[14:12];
   assign funct7_5     = instr[30];
   assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

   always_ff @(posedge clk) begin
      if (!rst) state <= S_FETCH;
      else      state <= state_next;
   end

   always_comb begin
      state_next = S_ERR;
      case (state)
         S_FETCH:  state_next = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_LOAD, OP_STORE: state_next = S_MEMADR;
               OP_RTYPE:          state_next = S_EXECR;
               OP_ITYPE:          state_next = S_EXECI;
               OP_BRANCH:         state_next = S_BRANCH;
               OP_JAL:            state_next = S_JAL;
               OP_JALR:           state_next = S_JALRADR;
               default:           state_next = S_ERR;
            endcase
         end
         S_MEMADR:   state_next = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  state_next = S_MEMWB;
         S_MEMWB:    state_next = S_FETCH;
         S_MEMWRITE: state_next = S_FETCH;
         S_EXECR:    state_next = S_ALUWB;
         S_EXECI:    state_next = S_ALUWB;
         S_ALUWB:    state_next = S_FETCH;
         S_BRANCH:   state_next = (funct3 == 3'b000 || funct3 == 3'b001) ? S_FETCH : S_ERR;
         S_JALRADR:  state_next = S_JAL;
         S_JAL:      state_next = S_ALUWB;
         default:    state_next = S_ERR;
      endcase
   end

   always_comb begin
      pc_we     = 1'b0;
      ir_we     = 1'b0;
      adr_src   = ADR_PC;
      mem_we    = 1'b0;
      reg_we    = 1'b0;
      alu_src_a = SRCA_PC;
      alu_src_b = SRCB_RS2;
      imm_src   = IMM_I;
      res_src   = RES_ALUOUT;
      alu_class = AC_ADD;
      err       = 1'b0;
      case (state)
         S_FETCH: begin
            ir_we     = 1'b1;
            pc_we     = 1'b1;
            alu_src_b = SRCB_FOUR;
            res_src   = RES_ALU;
         end
         S_DECODE: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_IMM;
            imm_src   = (opcode == OP_JAL) ? IMM_J : IMM_B;
         end
         S_MEMADR: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            imm_src   = (opcode == OP_LOAD) ? IMM_I : IMM_S;
         end
         S_MEMREAD:  adr_src = ADR_ALUOUT;
         S_MEMWB: begin
            res_src = RES_MEMDATA;
            reg_we  = 1'b1;
         end
         S_MEMWRITE: begin
            adr_src = ADR_ALUOUT;
            mem_we  = 1'b1;
         end
         S_EXECR: begin
            alu_src_a = SRCA_RS1;
            alu_class = AC_RTYPE;
         end
         S_EXECI: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            alu_class = AC_ITYPE;
         end
         S_ALUWB:    reg_we = 1'b1;
         S_BRANCH: begin
            alu_src_a = SRCA_RS1;
            alu_class = AC_SUB;
            pc_we     = (funct3 == 3'b000) ? zero :
                        (funct3 == 3'b001) ? ~zero : 1'b0;
         end
         S_JALRADR: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
         end
         S_JAL: begin
            pc_we     = 1'b1;
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_FOUR;
         end
         default:    err = 1'b1;
      endcase
      // Enables are suppressed for the whole time reset is held low
      if (!rst) begin
         pc_we  = PC_WE_IN_RESET;
         ir_we  = 1'b0;
         mem_we = 1'b0;
         reg_we = 1'b0;
      end
   end

   riscv_alu_dec u_alu_dec (
      .alu_class (alu_class),
      .funct3    (funct3),
      .funct7_5  (funct7_5),
      .alu_ctrl  (alu_ctrl)
   );

endmodule

// File: tb/tb_riscv_multi_ctrl.sv
// Cycle-by-cycle directed check of the multi-cycle controller outputs
// against hand-derived per-state expectations, with don't-care masking.
import riscv_multi_ctrl_pkg::*;

module tb_riscv_multi_ctrl;

   localparam int D = -1;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] instr = '0;
   logic        zero = 1'b0;
   logic        pc_we, ir_we, adr_src, mem_we, reg_we, err;
   logic [1:0]  alu_src_a, alu_src_b, imm_src, res_src;
   logic [3:0]  alu_ctrl;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       name;
      logic        rst;
      logic [31:0] instr;
      logic        zero;
      logic [35:0] exp;
   } vec_t;

   vec_t vecs[160];
   int   nvec = 0;

   riscv_multi_ctrl #(.RESET_PC_UPDATE(0)) dut (
      .clk(clk), .rst(rst), .instr(instr), .zero(zero),
      .pc_we(pc_we), .ir_we(ir_we), .adr_src(adr_src), .mem_we(mem_we),
      .reg_we(reg_we), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_ctrl(alu_ctrl), .imm_src(imm_src), .res_src(res_src), .err(err)
   );

   always #5 clk = ~clk;

   // Packs {care mask, value}; a negative field is don't-care
   function automatic logic [35:0] ex(int pc, int ir, int adr, int mw, int rw,
                                      int sa, int sb, int ac, int is, int rs, int er);
      logic [17:0] v, c;
      v = {pc[0], ir[0], adr[0], mw[0], rw[0], sa[1:0], sb[1:0], ac[3:0], is[1:0], rs[1:0], er[0]};
      c = {(pc < 0) ? 1'b0 : 1'b1, (ir < 0) ? 1'b0 : 1'b1, (adr < 0) ? 1'b0 : 1'b1,
           (mw < 0) ? 1'b0 : 1'b1, (rw < 0) ? 1'b0 : 1'b1,
           (sa < 0) ? 2'b00 : 2'b11, (sb < 0) ? 2'b00 : 2'b11,
           (ac < 0) ? 4'h0 : 4'hF, (is < 0) ? 2'b00 : 2'b11,
           (rs < 0) ? 2'b00 : 2'b11, (er < 0) ? 1'b0 : 1'b1};
      return {c, v & c};
   endfunction

   function automatic logic [35:0] s_fetch();            return ex(1,0+1,0,0,0,0,2,ALU_ADD,D,2,0); endfunction
   function automatic logic [35:0] s_decode(int is);     return ex(0,0,D,0,0,1,1,ALU_ADD,is,D,0); endfunction
   function automatic logic [35:0] s_memadr(int is);     return ex(0,0,D,0,0,2,1,ALU_ADD,is,D,0); endfunction
   function automatic logic [35:0] s_memread();          return ex(0,0,1,0,0,D,D,D,D,D,0); endfunction
   function automatic logic [35:0] s_memwb();            return ex(0,0,D,0,1,D,D,D,D,1,0); endfunction
   function automatic logic [35:0] s_memwrite();         return ex(0,0,1,1,0,D,D,D,D,D,0); endfunction
   function automatic logic [35:0] s_execr(int ac);      return ex(0,0,D,0,0,2,0,ac,D,D,0); endfunction
   function automatic logic [35:0] s_execi(int ac);      return ex(0,0,D,0,0,2,1,ac,0,D,0); endfunction
   function automatic logic [35:0] s_aluwb();            return ex(0,0,D,0,1,D,D,D,D,0,0); endfunction
   function automatic logic [35:0] s_branch(int pc);     return ex(pc,0,D,0,0,2,0,ALU_SUB,D,0,0); endfunction
   function automatic logic [35:0] s_jalradr();          return ex(0,0,D,0,0,2,1,ALU_ADD,0,D,0); endfunction
   function automatic logic [35:0] s_jal();              return ex(1,0,D,0,0,1,2,ALU_ADD,D,0,0); endfunction
   function automatic logic [35:0] s_err();              return ex(0,0,D,0,0,D,D,D,D,D,1); endfunction
   function automatic logic [35:0] s_rst(int er);        return ex(0,0,D,0,0,D,D,D,D,D,er); endfunction

   task automatic add(input string nm, input logic r, input logic [31:0] i,
                      input logic z, input logic [35:0] e);
      vecs[nvec] = '{name: nm, rst: r, instr: i, zero: z, exp: e};
      nvec++;
   endtask

   task automatic apply_chk(input string nm, input logic r, input logic [31:0] i,
                            input logic z, input logic [35:0] e);
      logic [17:0] act;
      @(negedge clk);
      rst = r; instr = i; zero = z;
      #1;
      act = {pc_we, ir_we, adr_src, mem_we, reg_we, alu_src_a, alu_src_b,
             alu_ctrl, imm_src, res_src, err};
      checks++;
      if ((act & e[35:18]) !== e[17:0]) begin
         errors++;
         $display("FAIL %s: got %h want %h (care mask %h)", nm, act, e[17:0], e[35:18]);
      end
   endtask

   task automatic add_r(input string nm, input logic [31:0] i, input int ac);
      add({nm, "_f"}, 1, i, 0, s_fetch());
      add({nm, "_d"}, 1, i, 0, s_decode(IMM_B));
      add({nm, "_x"}, 1, i, 0, s_execr(ac));
      add({nm, "_wb"}, 1, i, 0, s_aluwb());
   endtask

   task automatic add_i(input string nm, input logic [31:0] i, input int ac);
      add({nm, "_f"}, 1, i, 0, s_fetch());
      add({nm, "_d"}, 1, i, 0, s_decode(IMM_B));
      add({nm, "_x"}, 1, i, 0, s_execi(ac));
      add({nm, "_wb"}, 1, i, 0, s_aluwb());
   endtask

   task automatic add_br(input string nm, input logic [31:0] i, input logic z, input int pc);
      add({nm, "_f"}, 1, i, z, s_fetch());
      add({nm, "_d"}, 1, i, z, s_decode(IMM_B));
      add({nm, "_b"}, 1, i, z, s_branch(pc));
   endtask

   initial begin
      add("rst_a", 0, 32'h0, 0, s_rst(0));
      add("rst_b", 0, 32'h0, 0, s_rst(0));
      // lw x1,4(x2): 5 cycles, reg_we only in the last
      add("lw_f",  1, 32'h00412083, 0, s_fetch());
      add("lw_d",  1, 32'h00412083, 0, s_decode(IMM_B));
      add("lw_ma", 1, 32'h00412083, 0, s_memadr(IMM_I));
      add("lw_mr", 1, 32'h00412083, 0, s_memread());
      add("lw_wb", 1, 32'h00412083, 0, s_memwb());
      // sw x1,8(x2): 4 cycles
      add("sw_f",  1, 32'h00112423, 0, s_fetch());
      add("sw_d",  1, 32'h00112423, 0, s_decode(IMM_B));
      add("sw_ma", 1, 32'h00112423, 0, s_memadr(IMM_S));
      add("sw_mw", 1, 32'h00112423, 0, s_memwrite());
      add_r("add",  32'h002081b3, ALU_ADD);
      add_r("sub",  32'h40208133, ALU_SUB);
      add_r("xor",  32'h0020c1b3, ALU_XOR);
      add_r("sra",  32'h4020d1b3, ALU_SRA);
      add_r("sltu", 32'h0020b1b3, ALU_SLTU);
      add_r("and",  32'h0020f1b3, ALU_AND);
      add_r("sll",  32'h002091b3, ALU_SLL);
      add_i("addi_b30", 32'h40000093, ALU_ADD);
      add_i("srai",     32'h4030d093, ALU_SRA);
      add_i("srli",     32'h0030d093, ALU_SRL);
      add_i("ori",      32'h0ff0e093, ALU_OR);
      add_i("slti",     32'h0050a093, ALU_SLT);
      add_br("beq_t", 32'h00000463, 1, 1);
      add_br("beq_n", 32'h00000463, 0, 0);
      add_br("bne_t", 32'h00101463, 0, 1);
      add_br("bne_n", 32'h00101463, 1, 0);
      // jal ra,8: 4 cycles, J immediate in DECODE
      add("jal_f",  1, 32'h008000ef, 0, s_fetch());
      add("jal_d",  1, 32'h008000ef, 0, s_decode(IMM_J));
      add("jal_j",  1, 32'h008000ef, 0, s_jal());
      add("jal_wb", 1, 32'h008000ef, 0, s_aluwb());
      // jalr ra,4(x3): 5 cycles
      add("jalr_f",  1, 32'h004180e7, 0, s_fetch());
      add("jalr_d",  1, 32'h004180e7, 0, s_decode(IMM_B));
      add("jalr_a",  1, 32'h004180e7, 0, s_jalradr());
      add("jalr_j",  1, 32'h004180e7, 0, s_jal());
      add("jalr_wb", 1, 32'h004180e7, 0, s_aluwb());
      // Unsupported branch funct3 traps after BRANCH
      add_br("blt_bad", 32'h00004463, 1, 0);
      add("blt_err", 1, 32'h00004463, 1, s_err());
      add("blt_rst", 0, 32'h00004463, 1, s_rst(1));
      add("post_rst_f", 1, 32'h00000000, 0, s_fetch());
      add("ill_d",   1, 32'h00000000, 0, s_decode(IMM_B));
      add("ill_err", 1, 32'h00000000, 0, s_err());

      for (int k = 0; k < nvec; k++)
         apply_chk(vecs[k].name, vecs[k].rst, vecs[k].instr, vecs[k].zero, vecs[k].exp);

      // ERR stays put regardless of IR contents until reset
      for (int k = 0; k < 4; k++)
         apply_chk("err_sticky", 1, (k == 0) ? 32'h002081b3 : 32'h00412083, k[0], s_err());
      apply_chk("err_rst_hold", 0, 32'h00112423, 0, s_rst(1));
      apply_chk("err_rst_hold2", 0, 32'h00112423, 0, s_rst(0));

      // Reset asserted during MEMWRITE: no mem_we, then FETCH
      apply_chk("rmw_f",  1, 32'h00112423, 0, s_fetch());
      apply_chk("rmw_d",  1, 32'h00112423, 0, s_decode(IMM_B));
      apply_chk("rmw_ma", 1, 32'h00112423, 0, s_memadr(IMM_S));
      apply_chk("rmw_mw_rst", 0, 32'h00112423, 0, s_rst(0));
      apply_chk("rmw_fetch", 1, 32'h00112423, 0, s_fetch());
      apply_chk("rmw_dec", 1, 32'h00112423, 0, s_decode(IMM_B));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/riscv_multi_ctrl.md
Name: riscv_multi_ctrl

Overview:
- Control FSM for the multi-cycle RISC-V datapath: one shared ALU and one unified instruction/data memory, reused across cycles.
- Sequences fetch, decode, execute, memory and writeback per instruction.
- Drives every datapath select and write enable from the latched instruction register (IR) and the ALU zero flag.
- Sits alongside the datapath inside riscv_multi_top, replacing the single-cycle decoder.

Parameters:
- RESET_PC_UPDATE, 0, reserved for future use; must stay 0. Reset PC is owned by the datapath.

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  synchronous, active-low reset
- instr  in  32  current IR contents
- zero  in  1  ALU zero flag from the current cycle
- pc_we  out  1  PC register write enable
- ir_we  out  1  IR and old_pc register write enable
- adr_src  out  1  memory address select: 0 = PC, 1 = registered ALU result
- mem_we  out  1  data memory write enable
- reg_we  out  1  register file write enable
- alu_src_a  out  2  ALU A select: 0 = PC, 1 = old_pc, 2 = rs1
- alu_src_b  out  2  ALU B select: 0 = rs2, 1 = imm, 2 = constant 4
- alu_ctrl  out  4  ALU operation, encoded per alu.vh
- imm_src  out  2  immediate format: 0 = I, 1 = S, 2 = B, 3 = J
- res_src  out  2  result mux: 0 = alu_out register, 1 = mem data register, 2 = live ALU result
- err  out  1  illegal opcode trap; sticky until reset

Behaviour:
- Reset: rst low at a rising edge puts the state in FETCH and clears err. While rst is low, all enables (pc_we, ir_we, mem_we, reg_we) are forced to 0. Selects are don't-care.
- Reset mid-instruction abandons the instruction; no partial writes occur after the reset edge.
- Moore outputs per state. The single exception is pc_we in BRANCH, which also depends on zero.
- FETCH:
  - Outputs: adr_src=0, ir_we=1, alu_src_a=0, alu_src_b=2, alu_ctrl=ADD, res_src=2, pc_we=1.
  - Next state: DECODE.
- DECODE:
  - Outputs: alu_src_a=1, alu_src_b=1, imm_src=B, alu_ctrl=ADD. This precomputes old_pc+imm for branches.
  - Transitions on opcode:
    - 0000011 (lw) or 0100011 (sw) -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BRANCH
    - 1101111 -> JAL; DECODE uses imm_src=J for this opcode
    - 1100111 -> JALRADR
    - any other opcode -> ERR
- MEMADR:
  - Outputs: alu_src_a=2, alu_src_b=1, imm_src=I for lw / S for sw, ALU ADD.
  - Next state: MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: adr_src=1 -> MEMWB.
- MEMWB: res_src=1, reg_we=1 -> FETCH.
- MEMWRITE: adr_src=1, mem_we=1 -> FETCH.
- EXECR: alu_src_a=2, alu_src_b=0, alu_ctrl from funct3/funct7 -> ALUWB.
- EXECI: alu_src_a=2, alu_src_b=1, imm_src=I, alu_ctrl from funct3 -> ALUWB.
  - funct7[5] is honoured only for funct3=101 (SRAI).
- ALUWB: res_src=0, reg_we=1 -> FETCH.
- BRANCH:
  - Outputs: alu_src_a=2, alu_src_b=0, ALU SUB, res_src=0.
  - pc_we = zero for funct3=000 (beq), ~zero for funct3=001 (bne). Other funct3 values -> ERR.
  - Next state: FETCH.
- JALRADR: alu_src_a=2, alu_src_b=1, imm_src=I, ALU ADD -> JAL.
- JAL:
  - Outputs: res_src=0, pc_we=1, alu_src_a=1, alu_src_b=2, ALU ADD. This computes old_pc+4 for the link register.
  - Next state: ALUWB.
- ERR: all enables 0, err=1. Stays in ERR until reset.
- Cycle counts: lw 5; sw 4; R-type 4; I-type 4; branch 3; jal 4; jalr 5.
- alu_ctrl decode for funct3 000..111:
  - R-type: ADD (SUB if funct7[5]), SLL, SLT, SLTU, XOR, SRL (SRA if funct7[5]), OR, AND.
  - I-type uses the same table, except funct3=000 always decodes to ADD.

Decomposition:
- riscv/datapath.vh holds the shared constants:
  - encodings for alu_src_a, alu_src_b, res_src, imm_src and adr_src
  - opcode constants
- riscv/multi_ctrl.vh holds the state encoding (4-bit).
- ALU op codes come from alu.vh.
- One combinational sub-module, riscv_alu_dec, maps (state class, funct3, funct7[5]) to alu_ctrl.

Test Plan:
- rst low for 2 edges, then high -> FETCH in first cycle: ir_we=1, pc_we=1, mem_we=0, reg_we=0; err=0.
- lw x1,4(x2) (0x00412083), mem[x2+4]=0xCAFE0001 -> reg_we asserted only in cycle 5 with res_src=1; x1=0xCAFE0001; PC advances by 4.
- sw x1,8(x2) (0x00112423) -> mem_we=1 only in cycle 4 with adr_src=1; reg_we never asserted.
- add x3,x1,x2 (0x002081b3) with x1=5, x2=7 -> x3=12 after cycle 4.
- beq x0,x0,8 (0x00000463) at PC=0 -> PC=8 after 3 cycles.
- Same beq with x1≠x0 via bne x0,x1,8 (0x00101463) -> PC=8; with x1=0 -> PC=4.
- jalr ra,x3,4 (0x004180e7), x3=8, at PC=0 -> PC=12 and ra=4 after 5 cycles.
- IR=0x00000000 -> ERR after DECODE; err=1 and no enables.
- Assert rst during MEMWRITE -> err=0 and FETCH next, with no mem_we.
